// File: rtl/banked_data_memory_if.sv
// Load/store bus between a requester and banked_data_memory: one write port,
// one read port, plus the memory's ready indication.
interface banked_data_memory_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    ready;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    wr_err;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  ready, wr_err, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output ready, wr_err, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/banked_data_memory.sv
// Single-write/single-read word memory with byte enables, 1- or 2-cycle read
// latency, address checking and a zeroing sweep after reset.
module banked_data_memory #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    banked_data_memory_if.slave  bus_io
);
    localparam int unsigned     BeW      = DATA_WIDTH / 8;
    localparam int unsigned     Lsb      = $clog2(BeW);
    localparam int unsigned     IdxW     = $clog2(DEPTH);
    localparam longint unsigned MemBytes = longint'(DEPTH) * longint'(BeW);

    typedef enum logic {StClear, StReady} state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         cnt_q;
    logic                    ready_q;
    logic                    wr_err_q;
    logic                    v1_q, e1_q;
    logic [DATA_WIDTH-1:0]   d1_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_bad, rd_bad, wr_go, rd_acc;
    logic [IdxW-1:0]         wr_idx, rd_idx;

    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return ((a & ADDR_WIDTH'(BeW - 1)) != '0) || (64'(a) >= MemBytes);
    endfunction

    assign wr_bad = addr_bad(bus_io.wr_addr);
    assign rd_bad = addr_bad(bus_io.rd_addr);
    assign wr_idx = bus_io.wr_addr[Lsb +: IdxW];
    assign rd_idx = bus_io.rd_addr[Lsb +: IdxW];
    assign wr_go  = ready_q & bus_io.wr_en & ~wr_bad;
    assign rd_acc = ready_q & bus_io.rd_en;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IdxW'(DEPTH - 1)) begin
                        state_q <= StReady;
                        ready_q <= 1'b1;
                    end
                end
                StReady: ready_q <= 1'b1;
                default: state_q <= StClear;
            endcase
        end
    end

    // Array has no reset; the sweep owns the write port until ready.
    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < int'(BeW); i++) begin
                if (bus_io.wr_be[i]) mem_q[wr_idx][8*i +: 8] <= bus_io.wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_err_q <= 1'b0;
            v1_q     <= 1'b0;
            e1_q     <= 1'b0;
            d1_q     <= '0;
        end else begin
            wr_err_q <= ready_q & bus_io.wr_en & wr_bad;
            v1_q     <= rd_acc;
            e1_q     <= rd_acc & rd_bad;
            // Nonblocking array read gives read-first behaviour on collisions.
            if (rd_acc) d1_q <= rd_bad ? '0 : mem_q[rd_idx];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  v2_q, e2_q;
        logic [DATA_WIDTH-1:0] d2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                if (v1_q) d2_q <= d1_q;
            end
        end

        assign bus_io.rd_valid = v2_q;
        assign bus_io.rd_err   = e2_q;
        assign bus_io.rd_data  = d2_q;
    end else begin : g_lat1
        assign bus_io.rd_valid = v1_q;
        assign bus_io.rd_err   = e1_q;
        assign bus_io.rd_data  = d1_q;
    end

    assign bus_io.ready  = ready_q;
    assign bus_io.wr_err = wr_err_q;
endmodule

// File: tb/tb_banked_data_memory.sv
// Directed bench driving latency-1 and latency-2 instances with identical
// stimulus; expected reads are queued at issue and compared on rd_valid.
module tb_banked_data_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en, rd_en;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_be;

    banked_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    banked_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

    assign bus1.wr_en = wr_en;   assign bus2.wr_en = wr_en;
    assign bus1.wr_addr = wr_addr; assign bus2.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data; assign bus2.wr_data = wr_data;
    assign bus1.wr_be = wr_be;   assign bus2.wr_be = wr_be;
    assign bus1.rd_en = rd_en;   assign bus2.rd_en = rd_en;
    assign bus1.rd_addr = rd_addr; assign bus2.rd_addr = rd_addr;

    banked_data_memory #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .READ_LATENCY(1),
                         .CLEAR_ON_RESET(1))
        u_lat1 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus1));
    banked_data_memory #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .READ_LATENCY(2),
                         .CLEAR_ON_RESET(1))
        u_lat2 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] model [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n === 1'b1 && bus1.rd_valid === 1'b1) begin
            chk("lat1_valid_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("lat1_rd_data", 64'(bus1.rd_data), 64'(e.data));
                chk("lat1_rd_err", 64'(bus1.rd_err), 64'(e.err));
                chk("lat1_rd_latency", 64'(cyc), 64'(e.cyc + 1));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n === 1'b1 && bus2.rd_valid === 1'b1) begin
            chk("lat2_valid_expected", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("lat2_rd_data", 64'(bus2.rd_data), 64'(e.data));
                chk("lat2_rd_err", 64'(bus2.rd_err), 64'(e.err));
                chk("lat2_rd_latency", 64'(cyc), 64'(e.cyc + 2));
            end
        end
    end

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h40);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input logic [31:0] a);
        exp_t e;
        rd_en   = 1'b1;
        rd_addr = a;
        e.err   = bad_addr(a);
        e.data  = e.err ? 32'h0 : model[a[5:2]];
        e.cyc   = cyc;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic rd_step(input logic [31:0] a);
        issue_rd(a);
        step();
        rd_en = 1'b0;
    endtask

    task automatic wr_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic bad;
        bad     = bad_addr(a);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        if (!bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[a[5:2]][8*i +: 8] = d[8*i +: 8];
            end
        end
        step();
        wr_en = 1'b0;
        chk("lat1_wr_err", 64'(bus1.wr_err), 64'(bad));
        chk("lat2_wr_err", 64'(bus2.wr_err), 64'(bad));
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ready1"}, 64'(bus1.ready), 64'd0);
        chk({tag, "_valid1"}, 64'(bus1.rd_valid), 64'd0);
        chk({tag, "_data1"}, 64'(bus1.rd_data), 64'd0);
        chk({tag, "_rderr1"}, 64'(bus1.rd_err), 64'd0);
        chk({tag, "_wrerr1"}, 64'(bus1.wr_err), 64'd0);
        chk({tag, "_ready2"}, 64'(bus2.ready), 64'd0);
        chk({tag, "_valid2"}, 64'(bus2.rd_valid), 64'd0);
        chk({tag, "_data2"}, 64'(bus2.rd_data), 64'd0);
        chk({tag, "_rderr2"}, 64'(bus2.rd_err), 64'd0);
        chk({tag, "_wrerr2"}, 64'(bus2.wr_err), 64'd0);
    endtask

    // Called right after reset release; counts edges until ready rises.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus1.ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_ready_cycles"}, 64'(n), 64'd16);
        chk({tag, "_ready2"}, 64'(bus2.ready), 64'd1);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (3) step();
        reset_check("por");

        // Port requests during the sweep must be ignored.
        wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 32'h0;
        rst_n = 1'b1;
        wait_ready("sweep1");
        wr_en = 1'b0;
        rd_en = 1'b0;

        for (int i = 0; i < 16; i++) rd_step(32'(i * 4));
        idle(3);

        wr_step(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr_step(32'h10, 32'h0000_00AA, 4'b0001);
        rd_step(32'h10);
        idle(3);

        wr_step(32'h20, 32'h0000_0001, 4'b1111);
        issue_rd(32'h20);
        wr_step(32'h20, 32'h1234_5678, 4'b1111);
        rd_en = 1'b0;
        rd_step(32'h20);
        idle(3);

        wr_step(32'h02, 32'hCAFE_F00D, 4'b1111);
        idle(1);
        chk("wr_err_pulse1", 64'(bus1.wr_err), 64'd0);
        wr_step(32'h40, 32'hCAFE_F00D, 4'b1111);
        idle(1);
        chk("wr_err_pulse2", 64'(bus2.wr_err), 64'd0);
        wr_step(32'h04, 32'h5555_5555, 4'b0000);
        rd_step(32'h00);
        rd_step(32'h02);
        rd_step(32'h40);
        rd_step(32'h04);
        idle(3);

        wr_step(32'h00, 32'h1111_1111, 4'b1111);
        wr_step(32'h04, 32'h2222_2222, 4'b1111);
        wr_step(32'h08, 32'h3333_3333, 4'b1111);
        wr_step(32'h0C, 32'h4444_4444, 4'b1111);
        rd_step(32'h00);
        rd_step(32'h04);
        rd_step(32'h08);
        rd_step(32'h0C);
        idle(4);
        chk("b2b_drained1", 64'(q1.size()), 64'd0);
        chk("b2b_drained2", 64'(q2.size()), 64'd0);

        // Reset in the middle of a sweep.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        reset_check("mid_sweep");
        step();
        rst_n = 1'b1;
        wait_ready("sweep2");

        // Reset with two reads in flight; anything not yet delivered is dropped.
        wr_step(32'h10, 32'h5A5A_5A5A, 4'b1111);
        issue_rd(32'h10);
        step();
        issue_rd(32'h14);
        step();
        rd_en = 1'b0;
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        reset_check("inflight");
        idle(2);
        rst_n = 1'b1;
        wait_ready("sweep3");
        rd_step(32'h10);
        idle(4);
        chk("final_drained1", 64'(q1.size()), 64'd0);
        chk("final_drained2", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/banked_data_memory.md
Name: banked_data_memory

Overview:
- Parametrised successor to the core's single-word program/data memory.
- Provides one write port and one read port with byte-enable writes.
- Read latency is selectable (1 or 2 cycles); memory is cleared by a hardware sweep after reset.
- Out-of-range and misaligned accesses are flagged.
- Sits between the core's load/store unit and backing storage; also used as instruction memory with writes tied off.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- DEPTH, 1024, number of words; power of two, at least 2.
- ADDR_WIDTH, 32, byte-address width of both ports.
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = sweep all words to zero after reset; 0 = skip sweep, ready immediately.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  out  1  high when the memory accepts accesses (clear sweep finished).
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write byte address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i enables byte lane i.
- wr_err  out  1  one-cycle pulse: rejected write.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read byte address.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_WIDTH  read data.
- rd_err  out  1  asserted with rd_valid when the read was rejected.

Behaviour:
- Addressing:
  - LSB = log2(DATA_WIDTH/8); word index = addr[LSB +: log2(DEPTH)].
  - Misaligned (addr[LSB-1:0] != 0) or out-of-range (addr >= DEPTH*DATA_WIDTH/8) accesses are rejected.
- Reset (reset low, asynchronous):
  - ready=0, rd_valid=0, rd_data=0, wr_err=0, rd_err=0, pipeline valid bits cleared, FSM to CLEAR (or READY if CLEAR_ON_RESET=0), sweep counter=0.
  - Array contents are not reset asynchronously.
- FSM:
  - CLEAR: on each clk, write zero to word[counter]; counter++. After word DEPTH-1 is written, go to READY. Sweep takes exactly DEPTH cycles after reset release.
  - READY: ready=1. Normal operation; remains here until reset.
  - In CLEAR: wr_en and rd_en are ignored. No rd_valid, no error pulses, no array update from the ports.
- Write (READY, wr_en=1, valid address): at the clk edge, for each i with wr_be[i]=1, byte lane i of word[index] takes wr_data lane i; other lanes are unchanged. wr_be=0 is a legal no-op with no error.
- Rejected write: array unchanged; wr_err=1 for the following cycle.
- Read (READY, rd_en=1):
  - READ_LATENCY=1: rd_valid/rd_data/rd_err registered at the accepting edge; visible the next cycle.
  - READ_LATENCY=2: one additional output register stage.
  - Full throughput: one read per cycle, results delivered in order.
  - rd_valid deasserts the cycle after the last result; rd_data holds its last value when rd_valid=0.
- Rejected read: rd_valid=1, rd_err=1, rd_data=0 at the normal latency.
- Same-cycle read and write to the same word: read-first. The read returns the pre-write contents; the write lands.
- Reset mid-operation (during a sweep or with reads in flight): in-flight reads are discarded, no rd_valid is produced, and the sweep restarts from 0 after release.
- No back-pressure: the consumer must accept rd_valid when it is presented.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=16 -> ready rises exactly 16 cycles after release. Subsequent reads of 0x00..0x3C return 0x00000000, rd_err=0.
- Write 0xDEADBEEF to 0x10 with wr_be=4'b1111, then write 0x000000AA with wr_be=4'b0001 -> read 0x10 returns 0xDEADBEAA, rd_valid exactly READ_LATENCY cycles after rd_en (checked for latencies 1 and 2).
- Same cycle: write 0x12345678 and read of 0x20, whose old value is 0x00000001 -> read returns 0x00000001; next read of 0x20 returns 0x12345678.
- Write to 0x02 (misaligned) and to 0x40 (DEPTH=16) -> each produces a one-cycle wr_err pulse; arrays unchanged. Reads of the same addresses -> rd_valid=1, rd_err=1, rd_data=0.
- Back-to-back reads of 0x0,0x4,0x8,0xC on consecutive cycles -> four consecutive rd_valid cycles with data in order.
- reset pulsed low during sweep at count 7 and with two reads in flight -> outputs zero immediately, no stale rd_valid; sweep restarts and ready rises DEPTH cycles after release.
